mem_io_responder: RTL and testbench

// - Memory-side responder for the CPU byte bus (mem_a/mem_dout/mem_wr -> mem_din).
// - Holds a 2^ADDR_W-byte RAM and decodes the I/O window mem_a[17:16]==2'b11.
// - I/O window: 0x30000 UART byte in/out, 0x30004 cycle counter / program stop.
// - Drives io_buffer_full back to the CPU. Sits between the CPU top and the UART/testbench.

---
 rtl/memio_pkg.sv | 26 ++
 rtl/memio_fifo.sv | 62 ++++++
 rtl/mem_io_responder.sv | 239 +++++++++++++++++++++++
 tb/tb_mem_io_responder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memio_pkg.sv
// Shared constants and types for the memory/I-O responder.
// I/O window: mem_a[17:16] == 2'b11.
package memio_pkg;

   localparam logic [17:0] IO_UART_ADDR = 18'h30000;
   localparam logic [17:0] IO_CNT_ADDR  = 18'h30004;

   typedef enum logic [1:0] {
      RUN,
      STOP,
      HALTED
   } state_t;

   // Source of the byte presented on mem_din in the cycle after the access
   typedef enum logic [1:0] {
      SRC_RAM,
      SRC_RX,
      SRC_CNT,
      SRC_ZERO
   } rd_src_t;

   function automatic logic is_io(input logic [17:0] a);
      return a[17:16] == 2'b11;
   endfunction

endpackage

// File: rtl/memio_fifo.sv
// Small synchronous FIFO. DEPTH must be a power of 2.
// Push while full is accepted only together with a pop.
module memio_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count_q == '0);
   assign full     = (count_q == AW'(0) + (AW+1)'(DEPTH));
   assign count    = count_q;
   assign pop_data = mem[rd_ptr];
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || pop);

   // Storage write, no reset needed for the data array
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder for the CPU byte bus: RAM plus I/O window
// (UART byte at 0x30000, cycle counter / program stop at 0x30004).
// Optional feature macro: MEMIO_CYCLE_CNT_EN enables the cycle counter
// and its snapshot; without it 0x30004..0x30007 read as 0x00.
module mem_io_responder
   import memio_pkg::*;
#(
   parameter int unsigned ADDR_W      = 17,
   parameter int unsigned TX_DEPTH    = 8,
   parameter int unsigned RX_DEPTH    = 4,
   parameter int unsigned FULL_MARGIN = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        halt
);

   localparam int unsigned RAM_BYTES = 1 << ADDR_W;
   localparam int unsigned TX_CW     = $clog2(TX_DEPTH) + 1;
   localparam int unsigned RX_CW     = $clog2(RX_DEPTH) + 1;
   localparam logic [TX_CW-1:0] FULL_THRESH = TX_CW'(TX_DEPTH - FULL_MARGIN);

   // Address decode
   logic [17:0]       a18;
   logic [ADDR_W-1:0] ram_addr;
   logic              io_hit;
   logic              uart_hit;
   logic              cnt_hit;
   logic              stop_hit;

   assign a18      = mem_a[17:0];
   assign ram_addr = mem_a[ADDR_W-1:0];
   assign io_hit   = is_io(a18);
   assign uart_hit = (a18 == IO_UART_ADDR);
   assign cnt_hit  = (a18[17:2] == IO_CNT_ADDR[17:2]);
   assign stop_hit = (a18 == IO_CNT_ADDR);

   // FIFO wiring
   logic             tx_push;
   logic [7:0]       tx_push_data;
   logic             tx_pop;
   logic [7:0]       tx_head;
   logic             tx_full;
   logic             tx_empty;
   logic [TX_CW-1:0] tx_count;

   logic             rx_push;
   logic             rx_pop;
   logic [7:0]       rx_head;
   logic             rx_full;
   logic             rx_empty;
   logic [RX_CW-1:0] rx_count;

   memio_fifo #(
      .WIDTH (8),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk       (clk_in),
      .rst_n     (rst_in),
      .push      (tx_push),
      .push_data (tx_push_data),
      .pop       (tx_pop),
      .pop_data  (tx_head),
      .full      (tx_full),
      .empty     (tx_empty),
      .count     (tx_count)
   );

   memio_fifo #(
      .WIDTH (8),
      .DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .clk       (clk_in),
      .rst_n     (rst_in),
      .push      (rx_push),
      .push_data (rx_data),
      .pop       (rx_pop),
      .pop_data  (rx_head),
      .full      (rx_full),
      .empty     (rx_empty),
      .count     (rx_count)
   );

   assign tx_valid       = !tx_empty;
   assign tx_pop         = tx_valid && tx_ready;
   assign tx_data        = tx_empty ? '0 : tx_head;
   assign io_buffer_full = (tx_count >= FULL_THRESH);
   assign rx_ready       = !rx_full && (rx_count != RX_CW'(RX_DEPTH));
   assign rx_push        = rx_valid && rx_ready;

   // Run/stop control
   state_t state_q;
   state_t state_d;

   assign halt = (state_q != RUN);

   // State register
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and tx push; the terminating 0x00 bypasses the ignore rule
   always_comb begin
      state_d      = state_q;
      tx_push      = 1'b0;
      tx_push_data = mem_dout;
      case (state_q)
         RUN: begin
            if (mem_wr && stop_hit) begin
               state_d = STOP;
            end else if (mem_wr && uart_hit && (mem_dout != '0) && !tx_full) begin
               tx_push = 1'b1;
            end
         end
         STOP: begin
            if (!tx_full) begin
               tx_push      = 1'b1;
               tx_push_data = '0;
               state_d      = HALTED;
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // Read source selection; side effects (rx pop, snapshot) only on reads
   rd_src_t rd_src_d;
   rd_src_t rd_src_q;

   always_comb begin
      rd_src_d = SRC_ZERO;
      rx_pop   = 1'b0;
      if (!io_hit) begin
         rd_src_d = SRC_RAM;
      end else if (!mem_wr) begin
         if (uart_hit && !rx_empty) begin
            rd_src_d = SRC_RX;
            rx_pop   = 1'b1;
         end
`ifdef MEMIO_CYCLE_CNT_EN
         else if (cnt_hit) begin
            rd_src_d = SRC_CNT;
         end
`endif
      end
   end

   // RAM: write at the edge, synchronous read, write-first on the same address
   logic [7:0] ram [RAM_BYTES];
   logic [7:0] ram_q;

   always_ff @(posedge clk_in) begin
      if (mem_wr && !io_hit) begin
         ram[ram_addr] <= mem_dout;
         ram_q         <= mem_dout;
      end else begin
         ram_q <= ram[ram_addr];
      end
   end

   // Registered read source and popped rx byte
   logic [7:0] rx_byte_q;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         rd_src_q  <= SRC_ZERO;
         rx_byte_q <= '0;
      end else begin
         rd_src_q <= rd_src_d;
         if (rx_pop) begin
            rx_byte_q <= rx_head;
         end
      end
   end

   logic [7:0] cnt_byte_q;

`ifdef MEMIO_CYCLE_CNT_EN
   logic [31:0] cnt_q;
   logic [31:0] snap_q;

   // Free-running counter; a read of 0x30004 latches the snapshot and
   // returns byte 0 of that same value so the four bytes are coherent
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         cnt_q      <= '0;
         snap_q     <= '0;
         cnt_byte_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
         if (rd_src_d == SRC_CNT) begin
            case (a18[1:0])
               2'd0: begin
                  snap_q     <= cnt_q;
                  cnt_byte_q <= cnt_q[7:0];
               end
               2'd1:    cnt_byte_q <= snap_q[15:8];
               2'd2:    cnt_byte_q <= snap_q[23:16];
               default: cnt_byte_q <= snap_q[31:24];
            endcase
         end
      end
   end
`else
   assign cnt_byte_q = '0;
`endif

   // Output mux over registered sources
   always_comb begin
      mem_din = '0;
      case (rd_src_q)
         SRC_RAM:  mem_din = ram_q;
         SRC_RX:   mem_din = rx_byte_q;
         SRC_CNT:  mem_din = cnt_byte_q;
         default:  mem_din = '0;
      endcase
   end

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: stimulus updates a behavioural
// model and queues expected read bytes / tx bytes; a negedge monitor
// compares whatever the DUT presents.
module tb_mem_io_responder;

   localparam int TXD   = 8;
   localparam int THR   = 6;
   localparam int RXD   = 4;
   localparam logic [31:0] AMASK = 32'h1FFFF;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic [31:0] mem_a = 32'h3000C;
   logic [7:0]  mem_dout = '0;
   logic        mem_wr = 1'b0;
   logic [7:0]  mem_din;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        halt;

   mem_io_responder #(
      .ADDR_W      (17),
      .TX_DEPTH    (8),
      .RX_DEPTH    (4),
      .FULL_MARGIN (2)
   ) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .mem_a          (mem_a),
      .mem_dout       (mem_dout),
      .mem_wr         (mem_wr),
      .mem_din        (mem_din),
      .io_buffer_full (io_buffer_full),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready),
      .halt           (halt)
   );

   always #5 clk_in = ~clk_in;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model state
   logic [7:0]  mram [int];
   logic [7:0]  rx_m [$];
   int          tx_occ;
   logic        halted;
   logic        stop_pend;
   logic [31:0] cyc;
   logic [31:0] snap;

   // Scoreboard queues and per-cycle expected status
   logic [7:0]  rd_q [$];
   logic [7:0]  sb_tx [$];
   logic        rd_strobe = 1'b0;
   logic        rd_pend = 1'b0;
   logic        mon_en = 1'b0;
   logic        cur_txv, cur_iobf, cur_rxr, cur_halt;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
      end
   endtask

   // Monitor: inputs change at posedge+1, so negedge sees a settled cycle
   always @(negedge clk_in) begin
      if (!mon_en) begin
         rd_pend = 1'b0;
      end else begin
         if (rd_pend) begin
            if (rd_q.size() == 0) begin
               check("rd_queue_empty", 32'd1, 32'd0);
            end else begin
               check("mem_din", {24'd0, mem_din}, {24'd0, rd_q.pop_front()});
            end
         end
         rd_pend = rd_strobe;
         check("tx_valid", {31'd0, tx_valid}, {31'd0, cur_txv});
         check("io_buffer_full", {31'd0, io_buffer_full}, {31'd0, cur_iobf});
         check("rx_ready", {31'd0, rx_ready}, {31'd0, cur_rxr});
         check("halt", {31'd0, halt}, {31'd0, cur_halt});
         if (tx_valid && tx_ready) begin
            if (sb_tx.size() == 0) begin
               check("tx_unexpected", {24'd0, tx_data}, 32'hFFFF_FFFF);
            end else begin
               check("tx_data", {24'd0, tx_data}, {24'd0, sb_tx.pop_front()});
            end
         end
      end
   end

   // One bus cycle: drive, update the model with pre-edge state, advance
   task automatic step(input logic [31:0] a, input logic wr, input logic [7:0] d,
                       input logic txr, input logic rxv, input logic [7:0] rxd);
      logic [17:0] a18;
      logic        chk;
      logic [7:0]  exp;
      int          ra;
      int          tx_pre;
      int          rx_pre;
      int          push;
      a18 = a[17:0];
      mem_a = a; mem_wr = wr; mem_dout = d;
      tx_ready = txr; rx_valid = rxv; rx_data = rxd;
      tx_pre = tx_occ;
      rx_pre = rx_m.size();
      cur_txv  = (tx_pre > 0);
      cur_iobf = (tx_pre >= THR);
      cur_rxr  = (rx_pre < RXD);
      cur_halt = halted;
      chk = 1'b0;
      exp = '0;
      if (a18[17:16] != 2'b11) begin
         ra = int'(a & AMASK);
         if (wr) begin
            mram[ra] = d;
         end else if (mram.exists(ra)) begin
            chk = 1'b1;
            exp = mram[ra];
         end
      end else if (!wr) begin
         chk = 1'b1;
         if (a18 == 18'h30000) begin
            if (rx_pre > 0) exp = rx_m.pop_front();
         end else if (a18 >= 18'h30004 && a18 <= 18'h30007) begin
`ifdef MEMIO_CYCLE_CNT_EN
            if (a18 == 18'h30004) snap = cyc;
            exp = 8'((snap >> (8 * int'(a18 - 18'h30004))) & 32'hFF);
`else
            exp = '0;
`endif
         end
      end
      push = 0;
      if (stop_pend) begin
         if (tx_pre < TXD) begin
            push = 1;
            sb_tx.push_back(8'h00);
            stop_pend = 1'b0;
         end
      end else if (!halted && wr && a18 == 18'h30000) begin
         if (d != 8'h00 && tx_pre < TXD) begin
            push = 1;
            sb_tx.push_back(d);
         end
      end else if (!halted && wr && a18 == 18'h30004) begin
         halted = 1'b1;
         stop_pend = 1'b1;
      end
      tx_occ = tx_pre + push - ((txr && tx_pre > 0) ? 1 : 0);
      if (rxv && rx_pre < RXD) rx_m.push_back(rxd);
      if (chk) rd_q.push_back(exp);
      rd_strobe = chk;
      @(posedge clk_in); #1;
      cyc = cyc + 1;
   endtask

   task automatic idle(input logic txr, input int n);
      for (int i = 0; i < n; i++) step(32'h3000C, 1'b0, 8'h00, txr, 1'b0, 8'h00);
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      rd_strobe = 1'b0;
      rst_in = 1'b0;
      mem_wr = 1'b0; mem_a = 32'h3000C; mem_dout = '0;
      rx_valid = 1'b0; tx_ready = 1'b0;
      #1;
      check("rst_mem_din", {24'd0, mem_din}, 32'd0);
      check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_tx_data", {24'd0, tx_data}, 32'd0);
      check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
      check("rst_iobf", {31'd0, io_buffer_full}, 32'd0);
      check("rst_halt", {31'd0, halt}, 32'd0);
      @(posedge clk_in); #1;
      @(posedge clk_in); #1;
      rd_q.delete(); sb_tx.delete(); rx_m.delete();
      tx_occ = 0; halted = 1'b0; stop_pend = 1'b0; cyc = '0; snap = '0;
      cur_txv = 1'b0; cur_iobf = 1'b0; cur_rxr = 1'b1; cur_halt = 1'b0;
      rst_in = 1'b1;
      mon_en = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int r;
      @(posedge clk_in); #1;
      do_reset();

      // RAM write/read and alias
      step(32'h00010, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
      step(32'h00010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      step(32'h20010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      step(32'h00011, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h00);
      step(32'h00011, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

      // tx fill with tx_ready low; 0x00 never pushes
      step(32'h30000, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 6; i++) begin
         step(32'h30000, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00);
         if (i == 4) check("iobf_after5", {31'd0, io_buffer_full}, 32'd0);
      end
      check("iobf_after6", {31'd0, io_buffer_full}, 32'd1);
      step(32'h30000, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00);
      step(32'h30000, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00);
      step(32'h30000, 1'b1, 8'h42, 1'b0, 1'b0, 8'h00);
      step(32'h30000, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
      idle(1'b1, 10);
      check("tx_drained", sb_tx.size(), 32'd0);

      // rx single byte, then empty read
      step(32'h3000C, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A);
      step(32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      step(32'h30000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

      // Counter snapshot after a known number of cycles
      do_reset();
      idle(1'b0, 261);
      for (int i = 0; i < 4; i++) step(32'h30004 + 32'(i), 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

      // Program stop with queued bytes
      step(32'h30000, 1'b1, 8'h48, 1'b0, 1'b0, 8'h00);
      step(32'h30000, 1'b1, 8'h69, 1'b0, 1'b0, 8'h00);
      step(32'h30004, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00);
      check("halt_set", {31'd0, halt}, 32'd1);
      idle(1'b0, 1);
      step(32'h30000, 1'b1, 8'h58, 1'b0, 1'b0, 8'h00);
      step(32'h00010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      idle(1'b1, 6);
      check("tx_after_halt", sb_tx.size(), 32'd0);

      // Reset while stuck in STOP (tx full)
      do_reset();
      for (int i = 0; i < 8; i++) step(32'h30000, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00);
      step(32'h30004, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
      idle(1'b0, 2);
      check("halt_in_stop", {31'd0, halt}, 32'd1);
      do_reset();
      step(32'h00010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      idle(1'b0, 1);

      // Randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         if (i == 400) do_reset();
         r = $urandom_range(0, 99);
         if (r < 40) begin
            a = 32'h100 + 32'($urandom_range(0, 31)) + (($urandom_range(0, 1) == 1) ? 32'h20000 : 32'h0);
            a = a | ($urandom & 32'hFFFC_0000);
            step(a, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 1)), 8'($urandom));
         end else if (r < 60) begin
            step(32'h30000, 1'b1, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), 8'($urandom));
         end else if (r < 75) begin
            step(32'h30000, 1'b0, 8'h00, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 1)), 8'($urandom));
         end else if (r < 88) begin
            step(32'h30004 + 32'($urandom_range(0, 3)), 1'b0, 8'h00,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), 8'($urandom));
         end else if (r < 94) begin
            step(32'h30010 + 32'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), 8'($urandom));
         end else if (i > 600 && $urandom_range(0, 19) == 0) begin
            step(32'h30004, 1'b1, 8'($urandom), 1'b0, 1'b0, 8'h00);
         end else begin
            step(32'h30001 + 32'($urandom_range(0, 2)), 1'b0, 8'h00,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), 8'($urandom));
         end
      end
      idle(1'b1, 12);
      check("tx_final_drain", sb_tx.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
